// File: rtl/rr_pop_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin pop arbiter that moves
// words from the source FIFO bank to the destination FIFO bank.
package rr_pop_arbiter_pkg;

  localparam int DATA_W_DEF   = 12;
  localparam int DEST_MSB_DEF = 11;
  localparam int NUM_PORTS    = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    WAIT = 3'd2,
    PUSH = 3'd3,
    HOLD = 3'd4
  } state_e;

endpackage

// File: rtl/rr_pop_arbiter_rr_select.sv
// Combinational 4-way round-robin picker: the first requester after last_grant
// (wrapping mod 4) wins.
module rr_select
  import rr_pop_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] request,
  input  logic [1:0]           last_grant,
  output logic [1:0]           grant,
  output logic                 grant_valid
);

  logic [1:0] idx;

  // Walk from furthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = last_grant + 2'(i);
      if (request[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_pop_arbiter.sv
// Pops words from four source FIFOs in round-robin order and steers each one to
// the destination FIFO named by its class bits, waiting out almost_full.
module rr_pop_arbiter
  import rr_pop_arbiter_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEST_MSB = DEST_MSB_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          src_empty,
  input  logic [NUM_PORTS*DATA_W-1:0]   src_data,
  output logic [NUM_PORTS-1:0]          src_pop,
  input  logic [NUM_PORTS-1:0]          dst_almost_full,
  output logic [NUM_PORTS-1:0]          dst_push,
  output logic [DATA_W-1:0]             dst_data,
  output logic                          busy
);

  state_e                 state_q, state_d;
  logic [1:0]             last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]   src_pop_q, src_pop_d;
  logic [NUM_PORTS-1:0]   dst_push_q, dst_push_d;
  logic [DATA_W-1:0]      dst_data_q, dst_data_d;
  logic [DATA_W-1:0]      hold_word_q, hold_word_d;
  logic [1:0]             hold_dest_q, hold_dest_d;
  logic                   busy_q, busy_d;

  logic [1:0]             grant;
  logic                   grant_valid;
  logic [DATA_W-1:0]      src_word [NUM_PORTS];
  logic [DATA_W-1:0]      cap_word;
  logic [1:0]             cap_dest;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign src_word[i] = src_data[i*DATA_W +: DATA_W];
  end

  rr_select u_rr_select (
    .request     (~src_empty),
    .last_grant  (last_grant_q),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      src_pop_q    <= '0;
      dst_push_q   <= '0;
      dst_data_q   <= '0;
      hold_word_q  <= '0;
      hold_dest_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      src_pop_q    <= src_pop_d;
      dst_push_q   <= dst_push_d;
      dst_data_q   <= dst_data_d;
      hold_word_q  <= hold_word_d;
      hold_dest_q  <= hold_dest_d;
      busy_q       <= busy_d;
    end
  end

  // Pop and push default low so each pulse lasts exactly one cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    src_pop_d    = '0;
    dst_push_d   = '0;
    dst_data_d   = dst_data_q;
    hold_word_d  = hold_word_q;
    hold_dest_d  = hold_dest_q;
    cap_word     = src_word[last_grant_q];
    cap_dest     = cap_word[DEST_MSB -: 2];

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          src_pop_d[grant] = 1'b1;
          last_grant_d     = grant;
          state_d          = POP;
        end
      end
      POP: state_d = WAIT;
      WAIT: begin
        if (!dst_almost_full[cap_dest]) begin
          dst_data_d           = cap_word;
          dst_push_d[cap_dest] = 1'b1;
          state_d              = PUSH;
        end else begin
          hold_word_d = cap_word;
          hold_dest_d = cap_dest;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (!dst_almost_full[hold_dest_q]) begin
          dst_data_d              = hold_word_q;
          dst_push_d[hold_dest_q] = 1'b1;
          state_d                 = PUSH;
        end
      end
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign src_pop  = src_pop_q;
  assign dst_push = dst_push_q;
  assign dst_data = dst_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rr_pop_arbiter.sv
// Directed bench for rr_pop_arbiter: behavioural source FIFOs feed the DUT and
// each phase checks pop/push pulses against hand-computed values.
module tb_rr_pop_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   src_empty;
  logic [47:0]  src_data;
  logic [3:0]   src_pop;
  logic [3:0]   dst_almost_full;
  logic [3:0]   dst_push;
  logic [11:0]  dst_data;
  logic         busy;

  logic [11:0]  srcQ [4][$];
  logic [11:0]  srcOut [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_pop_arbiter #(.DATA_W(12), .DEST_MSB(11)) dut (
    .clk             (clk),
    .reset           (reset),
    .src_empty       (src_empty),
    .src_data        (src_data),
    .src_pop         (src_pop),
    .dst_almost_full (dst_almost_full),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .busy            (busy)
  );

  assign src_data = {srcOut[3], srcOut[2], srcOut[1], srcOut[0]};

  // Source FIFO model: a popped word appears on fifo_out the following cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (src_pop[i] && srcQ[i].size() > 0) srcOut[i] <= srcQ[i].pop_front();
    end
    for (int i = 0; i < 4; i++) src_empty[i] <= (srcQ[i].size() == 0);
  end

  function automatic logic [3:0] oneHot(input int i);
    logic [3:0] v;
    v = 4'b0001;
    return v << i;
  endfunction

  function automatic logic [11:0] rrWord(input int src, input int j);
    logic [1:0] d;
    d = 2'((src + j) % 4);
    return {d, 10'(src * 16 + j)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int src, input logic [11:0] word);
    srcQ[src].push_back(word);
  endtask

  task automatic waitPop(input int src);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (src_pop != 4'b0) break;
    end
    checkOutput("popGrant", 32'(src_pop), 32'(oneHot(src)));
  endtask

  task automatic checkPushSeq(input logic [11:0] word, input int dest);
    @(negedge clk);
    checkOutput("popWidth", 32'(src_pop), 32'h0);
    checkOutput("pushEarly", 32'(dst_push), 32'h0);
    @(negedge clk);
    checkOutput("pushDest", 32'(dst_push), 32'(oneHot(dest)));
    checkOutput("pushData", 32'(dst_data), 32'(word));
    @(negedge clk);
    checkOutput("pushWidth", 32'(dst_push), 32'h0);
    checkOutput("idleBusy", 32'(busy), 32'h0);
  endtask

  task automatic doTransfer(input int src, input logic [11:0] word, input int dest);
    waitPop(src);
    checkPushSeq(word, dest);
  endtask

  initial begin
    reset           = 1'b0;
    dst_almost_full = 4'b0;

    $display("[TB] reset and round-robin over four loaded sources");
    for (int j = 0; j < 3; j++)
      for (int s = 0; s < 4; s++) applyStimulus(s, rrWord(s, j));
    repeat (2) @(negedge clk);
    checkOutput("rstPop", 32'(src_pop), 32'h0);
    checkOutput("rstPush", 32'(dst_push), 32'h0);
    checkOutput("rstData", 32'(dst_data), 32'h0);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    reset = 1'b1;

    for (int k = 0; k < 48; k++) begin
      int n;
      @(negedge clk);
      n = k / 4;
      checkOutput("rrPop", 32'(src_pop), (k % 4 == 0) ? 32'(oneHot(n % 4)) : 32'h0);
      checkOutput("rrBusy", 32'(busy), (k % 4 == 3) ? 32'h0 : 32'h1);
      if (k % 4 == 2) begin
        checkOutput("rrPush", 32'(dst_push), 32'(oneHot(((n % 4) + (n / 4)) % 4)));
        checkOutput("rrData", 32'(dst_data), 32'(rrWord(n % 4, n / 4)));
      end else begin
        checkOutput("rrNoPush", 32'(dst_push), 32'h0);
      end
    end
    repeat (3) begin
      @(negedge clk);
      checkOutput("allEmptyPop", 32'(src_pop), 32'h0);
      checkOutput("allEmptyBusy", 32'(busy), 32'h0);
    end

    $display("[TB] single word from source 2");
    applyStimulus(2, 12'h8A5);
    doTransfer(2, 12'h8A5, 2);
    repeat (2) begin
      @(negedge clk);
      checkOutput("singleQuiet", 32'({src_pop, dst_push}), 32'h0);
    end

    $display("[TB] back-pressure on destination 3");
    dst_almost_full[3] = 1'b1;
    applyStimulus(0, 12'hC01);
    waitPop(0);
    repeat (10) begin
      @(negedge clk);
      checkOutput("holdNoPush", 32'(dst_push), 32'h0);
      checkOutput("holdBusy", 32'(busy), 32'h1);
    end
    dst_almost_full[3] = 1'b0;
    @(negedge clk);
    checkOutput("holdPush", 32'(dst_push), 32'h8);
    checkOutput("holdData", 32'(dst_data), 32'hC01);
    @(negedge clk);
    checkOutput("holdPushWidth", 32'(dst_push), 32'h0);

    $display("[TB] reset while holding a word");
    dst_almost_full[1] = 1'b1;
    applyStimulus(1, 12'h4AB);
    waitPop(1);
    repeat (4) @(negedge clk);
    checkOutput("preRstBusy", 32'(busy), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midRstPush", 32'(dst_push), 32'h0);
    checkOutput("midRstData", 32'(dst_data), 32'h0);
    checkOutput("midRstBusy", 32'(busy), 32'h0);
    checkOutput("midRstPop", 32'(src_pop), 32'h0);
    reset = 1'b1;
    dst_almost_full[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checkOutput("heldDropped", 32'({src_pop, dst_push}), 32'h0);
    end

    $display("[TB] sparse requests with wrap");
    applyStimulus(3, 12'h0F3);
    waitPop(3);
    applyStimulus(0, 12'h5A0);
    applyStimulus(1, 12'hBA1);
    checkPushSeq(12'h0F3, 0);
    doTransfer(0, 12'h5A0, 1);
    doTransfer(1, 12'hBA1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_pop_arbiter.md
Name: rr_pop_arbiter

Overview:
- Downstream consumer of four fifoMod instances (source FIFOs 0..3).
- Pops one word at a time from non-empty sources in round-robin order.
- Steers each word to one of four destination FIFOs, selected by the word's class bits.
- Honours destination almost_full back-pressure. Sits between the input FIFO bank and the output FIFO bank.

Parameters:
- DATA_W, 12, word width; matches fifoMod fifo_in/fifo_out.
- DEST_MSB, 11, upper bit of the 2-bit destination field (field is [DEST_MSB:DEST_MSB-1]).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low (reset==0 at a clk rising edge resets the block).
- src_empty  in  4  empty flags of source FIFOs 0..3.
- src_data  in  4*DATA_W  concatenated fifo_out of sources; source i occupies [i*DATA_W +: DATA_W].
- src_pop  out  4  one-hot fifo_rd (pop) to sources.
- dst_almost_full  in  4  almost_full flags of destination FIFOs 0..3.
- dst_push  out  4  one-hot fifo_wr (push) to destinations.
- dst_data  out  DATA_W  fifo_in shared by all destinations.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: src_pop=0, dst_push=0, dst_data=0, busy=0, state=IDLE, last_grant=3 (so source 0 has first priority).
- All outputs are registered. No combinational path from input to output.
- Source timing: a source FIFO's fifo_out is valid in the cycle after the cycle in which its pop is high.
- FSM states: IDLE, POP, WAIT, PUSH, HOLD.
- IDLE:
  - Search sources last_grant+1, +2, +3, +4 (mod 4) and take the first with src_empty==0.
  - If found: grant g, src_pop[g]<=1, last_grant<=g, go to POP.
  - Otherwise stay in IDLE.
- POP: src_pop<=0 (pop is exactly 1 cycle wide), go to WAIT.
- WAIT:
  - Capture word = src_data[g]; dest d = word[DEST_MSB:DEST_MSB-1].
  - If dst_almost_full[d]==0: dst_data<=word, dst_push[d]<=1, go to PUSH.
  - Otherwise: latch word and d, go to HOLD.
- HOLD:
  - Each cycle re-check dst_almost_full[d].
  - When it is 0: dst_data<=latched word, dst_push[d]<=1, go to PUSH.
  - The latched word is never dropped and never overwritten.
- PUSH: dst_push<=0 (push is exactly 1 cycle wide), go to IDLE. dst_data holds its value until the next push.
- Throughput: 4 cycles per word with no back-pressure (IDLE→POP→WAIT→PUSH).
- Fairness: a source re-granted while another source is non-empty waits at most 3 grants.
- src_empty is sampled only in IDLE. A source that goes empty after grant has already been popped; no second pop is issued.
- At most one bit of src_pop, and at most one bit of dst_push, is ever high.
- src_pop and dst_push are never high in the same cycle.
- Pointer wrap of last_grant is mod 4 (2-bit natural overflow).
- Reset mid-operation: any state returns to IDLE next edge and all outputs clear. An in-flight popped word is discarded; this is accepted, and the system resets the FIFOs together.
- All four src_empty==1: stay in IDLE, all outputs quiet.

Decomposition:
- Shared package/include: DATA_W default, destination field position, FSM state encodings (3-bit: IDLE=0, POP=1, WAIT=2, PUSH=3, HOLD=4), source/destination count (4).
- One sub-module, rr_select: combinational 4-way round-robin priority picker.
  - Inputs: request[3:0], last_grant[1:0].
  - Outputs: grant[1:0], grant_valid.
- The FSM and datapath stay in rr_pop_arbiter.

Test Plan:
- Reset: hold reset=0 for 2 edges with sources non-empty → all outputs 0, busy=0. Release → src_pop=4'b0001 exactly 1 edge later.
- Single word: source 2 holds 12'h8A5 (dest 2) → src_pop=4'b0100 for 1 cycle; two cycles later dst_push=4'b0100 with dst_data=12'h8A5; no other pulses.
- Round-robin: all four sources hold 3 words each → grant order 0,1,2,3,0,1,2,3,0,1,2,3; 12 pushes spaced 4 cycles apart.
- Back-pressure: word 12'hC01 (dest 3) with dst_almost_full[3]=1 for 10 cycles → FSM in HOLD, no push. Drop almost_full → dst_push=4'b1000 and dst_data=12'hC01 on the next edge.
- Reset mid-HOLD: assert reset in HOLD → next edge state IDLE, dst_push=0, dst_data=0; the held word is never pushed.
- Sparse requests: only source 3 non-empty, last_grant=3 → grant 3 is found after wrap. Sources 0 and 1 become non-empty during the transfer → next grants are 0, then 1.
